mem_bus_responder: RTL and testbench

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

---
 rtl/mem_bus_responder.sv | 179 +++++++++++++++++
 tb/tb_mem_bus_responder.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: byte/word/dword load-store responder in front of a
// single-port 32-bit RAM without byte enables. Sub-word stores use a
// read-modify-write sequence. Optional build macro MEM_BUS_ALIGN_CHECK_EN
// turns misaligned accesses into rejected requests; without it they are
// silently aligned down.
module mem_bus_responder #(
   parameter int unsigned ADDR_BITS    = 10,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] bus_addr,
   input  logic [1:0]  bus_mem_width,
   input  logic        bus_dispatch_read,
   input  logic        bus_dispatch_write,
   input  logic [31:0] bus_write_data,
   output logic [31:0] bus_read_data,
   output logic        bus_busy,
   output logic        protocol_err
);

   localparam int unsigned DEPTH    = 2 ** ADDR_BITS;
   localparam logic [3:0]  LAST_CNT = 4'(READ_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_READ, WR_COMMIT} state_t;

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic [31:0]          rdata_q, rdata_d;
   logic [ADDR_BITS-1:0] idx_q;
   logic [1:0]           lane_q, width_q;
   logic [31:0]          wdata_q;
   logic                 misalign_q;

   logic [31:0]          mem [DEPTH];
   logic [31:0]          ram_q;
   logic [ADDR_BITS-1:0] rd_idx;
   logic                 ram_we;

   logic                 dispatch;
   logic [1:0]           w_norm;
   logic [1:0]           lane_in;
   logic                 acc_err;
   logic [31:0]          ext_data;
   logic [31:0]          merged;
   logic                 unused_addr_hi;

   assign unused_addr_hi = ^bus_addr[31:ADDR_BITS+2];
   assign dispatch       = bus_dispatch_read | bus_dispatch_write;
   // Width code 3 behaves as DWORD.
   assign w_norm         = (bus_mem_width == 2'd3) ? 2'd2 : bus_mem_width;

   // Lane offset of the access, with offending low bits aligned down.
   always_comb begin
      lane_in = 2'b00;
      unique case (w_norm)
         2'd0:    lane_in = bus_addr[1:0];
         2'd1:    lane_in = {bus_addr[1], 1'b0};
         default: lane_in = 2'b00;
      endcase
   end

`ifdef MEM_BUS_ALIGN_CHECK_EN
   assign acc_err = ((w_norm == 2'd1) && bus_addr[0]) ||
                    ((w_norm == 2'd2) && (bus_addr[1:0] != 2'b00));
`else
   assign acc_err = 1'b0;
`endif

   // Extract the addressed lane from the RAM word, zero-extended.
   always_comb begin
      ext_data = ram_q;
      unique case (width_q)
         2'd0:    ext_data = {24'd0, ram_q[{lane_q, 3'b000} +: 8]};
         2'd1:    ext_data = {16'd0, ram_q[{lane_q[1], 4'b0000} +: 16]};
         default: ext_data = ram_q;
      endcase
   end

   // Merge store data into the old RAM word, preserving the other lanes.
   always_comb begin
      merged = ram_q;
      unique case (width_q)
         2'd0:    merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
         2'd1:    merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   // Next-state, error pulse and read-result logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      rdata_d = rdata_q;
      ram_we  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = 4'd0;
            if (bus_dispatch_write) begin
               // A simultaneous read is dropped and flagged.
               state_d = (w_norm == 2'd2) ? WR_COMMIT : RMW_READ;
               err_d   = bus_dispatch_read | acc_err;
            end else if (bus_dispatch_read) begin
               state_d = RD_WAIT;
               err_d   = acc_err;
            end
         end
         RD_WAIT: begin
            err_d = dispatch;
            if (cnt_q == LAST_CNT) begin
               rdata_d = misalign_q ? 32'd0 : ext_data;
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         RMW_READ: begin
            err_d = dispatch;
            if (cnt_q == LAST_CNT) begin
               state_d = WR_COMMIT;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         WR_COMMIT: begin
            err_d   = dispatch;
            ram_we  = ~misalign_q & ~rst_in;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state with synchronous reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Capture the request fields when a dispatch is accepted.
   always_ff @(posedge clk_in) begin
      if ((state_q == IDLE) && dispatch) begin
         idx_q      <= bus_addr[ADDR_BITS+1:2];
         lane_q     <= lane_in;
         width_q    <= w_norm;
         wdata_q    <= bus_write_data;
         misalign_q <= acc_err;
      end
   end

   // Read from the live bus address while idle so data is ready one cycle on.
   assign rd_idx = (state_q == IDLE) ? bus_addr[ADDR_BITS+1:2] : idx_q;

   // Single-port RAM, registered read, not cleared by reset.
   always_ff @(posedge clk_in) begin
      if (ram_we) begin
         mem[idx_q] <= merged;
      end
      ram_q <= mem[rd_idx];
   end

   assign bus_read_data = rdata_q;
   assign protocol_err  = err_q;
   assign bus_busy      = ~rst_in & ((state_q != IDLE) | dispatch);

endmodule

// File: tb/tb_mem_bus_responder.sv
// Testbench for mem_bus_responder: directed scenarios plus randomized
// traffic checked against a byte-level memory model.
module tb_mem_bus_responder;

   localparam int unsigned ADDR_BITS = 10;
   localparam int unsigned LAT       = 1;
`ifdef MEM_BUS_ALIGN_CHECK_EN
   localparam bit ALIGN_CHK = 1'b1;
`else
   localparam bit ALIGN_CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] bus_addr;
   logic [1:0]  bus_mem_width;
   logic        bus_dispatch_read;
   logic        bus_dispatch_write;
   logic [31:0] bus_write_data;
   logic [31:0] bus_read_data;
   logic        bus_busy;
   logic        protocol_err;

   int checks   = 0;
   int failures = 0;

   logic [31:0] ref_mem [int unsigned];
   logic [31:0] exp_rdata;

   mem_bus_responder #(
      .ADDR_BITS    (ADDR_BITS),
      .READ_LATENCY (LAT)
   ) dut (
      .clk_in             (clk),
      .rst_in             (rst),
      .bus_addr           (bus_addr),
      .bus_mem_width      (bus_mem_width),
      .bus_dispatch_read  (bus_dispatch_read),
      .bus_dispatch_write (bus_dispatch_write),
      .bus_write_data     (bus_write_data),
      .bus_read_data      (bus_read_data),
      .bus_busy           (bus_busy),
      .protocol_err       (protocol_err)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int unsigned word_of(input logic [31:0] a);
      return (a / 4) % (1 << ADDR_BITS);
   endfunction

   function automatic int unsigned size_of(input logic [1:0] w);
      if (w == 2'd0) return 1;
      if (w == 2'd1) return 2;
      return 4;
   endfunction

   function automatic bit is_misaligned(input logic [31:0] a, input logic [1:0] w);
      return ((a % 4) % size_of(w)) != 0;
   endfunction

   function automatic int unsigned offset_of(input logic [31:0] a, input logic [1:0] w);
      int unsigned o;
      o = a % 4;
      return o - (o % size_of(w));
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] w);
      logic [31:0] word;
      logic [31:0] r;
      int unsigned off;
      word = ref_mem[word_of(a)];
      off  = offset_of(a, w);
      r    = 32'd0;
      for (int i = 0; i < int'(size_of(w)); i++) r[8*i +: 8] = word[8*(off+i) +: 8];
      return r;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
      logic [31:0] word;
      int unsigned off;
      word = ref_mem.exists(word_of(a)) ? ref_mem[word_of(a)] : 32'd0;
      off  = offset_of(a, w);
      for (int i = 0; i < int'(size_of(w)); i++) word[8*(off+i) +: 8] = d[8*i +: 8];
      ref_mem[word_of(a)] = word;
   endtask

   // Drive one request in the current cycle and run until busy drops.
   task automatic do_op(input bit rd, input bit wr, input logic [1:0] w, input logic [31:0] a,
                        input logic [31:0] d, output int cyc, output bit err);
      bus_dispatch_read  = rd;
      bus_dispatch_write = wr;
      bus_mem_width      = w;
      bus_addr           = a;
      bus_write_data     = d;
      cyc = 0;
      err = 1'b0;
      #1;
      while (bus_busy === 1'b1 && cyc < 64) begin
         cyc++;
         @(posedge clk);
         #1;
         bus_dispatch_read  = 1'b0;
         bus_dispatch_write = 1'b0;
         #1;
         if (protocol_err === 1'b1) err = 1'b1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst                = 1'b1;
      bus_dispatch_read  = 1'b1;
      bus_dispatch_write = 1'b0;
      bus_addr           = 32'h0;
      bus_mem_width      = 2'd2;
      bus_write_data     = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy: got %b expected 0", bus_busy);
      end
      checks++;
      if (bus_read_data !== 32'd0) begin
         failures++;
         $display("FAIL reset_rdata: got %h expected 00000000", bus_read_data);
      end
      checks++;
      if (protocol_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_err: got %b expected 0", protocol_err);
      end
      bus_dispatch_read = 1'b0;
      rst               = 1'b0;
      exp_rdata         = 32'd0;
      @(posedge clk);
      #1;
      checks++;
      if (bus_busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_busy: got %b expected 0", bus_busy);
      end
   endtask

   task automatic test_directed;
      int cyc;
      bit err;
      do_op(1'b0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, cyc, err);
      model_write(32'h10, 2'd2, 32'hDEADBEEF);
      checks++;
      if (cyc != 2) begin
         failures++;
         $display("FAIL dword_write_busy: got %0d expected 2", cyc);
      end
      do_op(1'b1, 1'b0, 2'd2, 32'h10, 32'h0, cyc, err);
      checks++;
      if (cyc != 2) begin
         failures++;
         $display("FAIL dword_read_busy: got %0d expected 2", cyc);
      end
      checks++;
      if (bus_read_data !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL dword_read_data: got %h expected deadbeef", bus_read_data);
      end
      do_op(1'b0, 1'b1, 2'd0, 32'h11, 32'h55, cyc, err);
      model_write(32'h11, 2'd0, 32'h55);
      checks++;
      if (cyc != 3) begin
         failures++;
         $display("FAIL byte_write_busy: got %0d expected 3", cyc);
      end
      checks++;
      if (bus_read_data !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL write_keeps_rdata: got %h expected deadbeef", bus_read_data);
      end
      do_op(1'b1, 1'b0, 2'd2, 32'h10, 32'h0, cyc, err);
      checks++;
      if (bus_read_data !== 32'hDEAD55EF) begin
         failures++;
         $display("FAIL rmw_merge: got %h expected dead55ef", bus_read_data);
      end
      do_op(1'b1, 1'b0, 2'd1, 32'h12, 32'h0, cyc, err);
      checks++;
      if (bus_read_data !== 32'h0000DEAD) begin
         failures++;
         $display("FAIL word_read_hi: got %h expected 0000dead", bus_read_data);
      end
      do_op(1'b1, 1'b0, 2'd0, 32'h13, 32'h0, cyc, err);
      checks++;
      if (bus_read_data !== 32'h000000DE) begin
         failures++;
         $display("FAIL byte_read_3: got %h expected 000000de", bus_read_data);
      end
      exp_rdata = 32'h000000DE;
   endtask

   task automatic test_align;
      int cyc;
      bit err;
      do_op(1'b1, 1'b0, 2'd2, 32'h12, 32'h0, cyc, err);
      checks++;
      if (cyc != 2) begin
         failures++;
         $display("FAIL align_busy: got %0d expected 2", cyc);
      end
      checks++;
      if (err !== ALIGN_CHK) begin
         failures++;
         $display("FAIL align_err: got %b expected %b", err, ALIGN_CHK);
      end
      exp_rdata = ALIGN_CHK ? 32'd0 : 32'hDEAD55EF;
      checks++;
      if (bus_read_data !== exp_rdata) begin
         failures++;
         $display("FAIL align_rdata: got %h expected %h", bus_read_data, exp_rdata);
      end
   endtask

   task automatic test_overlap;
      int cyc;
      bit err;
      bus_dispatch_write = 1'b1;
      bus_mem_width      = 2'd2;
      bus_addr           = 32'h30;
      bus_write_data     = 32'hA5A50001;
      @(posedge clk);
      #1;
      bus_dispatch_write = 1'b0;
      bus_dispatch_read  = 1'b1;
      bus_addr           = 32'h10;
      #1;
      checks++;
      if (bus_busy !== 1'b1) begin
         failures++;
         $display("FAIL overlap_busy: got %b expected 1", bus_busy);
      end
      @(posedge clk);
      #1;
      bus_dispatch_read = 1'b0;
      #1;
      checks++;
      if (protocol_err !== 1'b1) begin
         failures++;
         $display("FAIL overlap_err: got %b expected 1", protocol_err);
      end
      checks++;
      if (bus_busy !== 1'b0) begin
         failures++;
         $display("FAIL overlap_ignored: got busy %b expected 0", bus_busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (protocol_err !== 1'b0 || bus_read_data !== exp_rdata) begin
         failures++;
         $display("FAIL overlap_after: got err %b rdata %h expected err 0 rdata %h",
                  protocol_err, bus_read_data, exp_rdata);
      end
      model_write(32'h30, 2'd2, 32'hA5A50001);
      do_op(1'b1, 1'b0, 2'd2, 32'h30, 32'h0, cyc, err);
      exp_rdata = model_read(32'h30, 2'd2);
      checks++;
      if (bus_read_data !== exp_rdata) begin
         failures++;
         $display("FAIL overlap_write_done: got %h expected %h", bus_read_data, exp_rdata);
      end
   endtask

   task automatic test_simultaneous;
      int cyc;
      bit err;
      do_op(1'b1, 1'b1, 2'd1, 32'h32, 32'h00001234, cyc, err);
      model_write(32'h32, 2'd1, 32'h00001234);
      checks++;
      if (cyc != int'(LAT) + 2 || err !== 1'b1 || bus_read_data !== exp_rdata) begin
         failures++;
         $display("FAIL simul_rw: got busy %0d err %b rdata %h expected busy %0d err 1 rdata %h",
                  cyc, err, bus_read_data, LAT + 2, exp_rdata);
      end
      do_op(1'b1, 1'b0, 2'd2, 32'h30, 32'h0, cyc, err);
      exp_rdata = model_read(32'h30, 2'd2);
      checks++;
      if (bus_read_data !== exp_rdata) begin
         failures++;
         $display("FAIL simul_write_done: got %h expected %h", bus_read_data, exp_rdata);
      end
   endtask

   task automatic test_reset_commit;
      int cyc;
      bit err;
      do_op(1'b0, 1'b1, 2'd2, 32'h20, 32'hCAFEF00D, cyc, err);
      model_write(32'h20, 2'd2, 32'hCAFEF00D);
      bus_dispatch_write = 1'b1;
      bus_mem_width      = 2'd2;
      bus_addr           = 32'h20;
      bus_write_data     = 32'h12345678;
      @(posedge clk);
      #1;
      bus_dispatch_write = 1'b0;
      #1;
      checks++;
      if (bus_busy !== 1'b1) begin
         failures++;
         $display("FAIL commit_busy: got %b expected 1", bus_busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus_busy !== 1'b0) begin
         failures++;
         $display("FAIL busy_in_reset: got %b expected 0", bus_busy);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      exp_rdata = 32'd0;
      checks++;
      if (bus_busy !== 1'b0 || bus_read_data !== 32'd0) begin
         failures++;
         $display("FAIL after_reset: got busy %b rdata %h expected busy 0 rdata 00000000",
                  bus_busy, bus_read_data);
      end
      do_op(1'b1, 1'b0, 2'd2, 32'h20, 32'h0, cyc, err);
      exp_rdata = model_read(32'h20, 2'd2);
      checks++;
      if (bus_read_data !== 32'hCAFEF00D || exp_rdata !== 32'hCAFEF00D) begin
         failures++;
         $display("FAIL write_suppressed: got %h expected cafef00d", bus_read_data);
      end
   endtask

   task automatic test_random;
      int          cyc;
      int          exp_cyc;
      bit          err;
      bit          rd;
      bit          mis;
      logic [1:0]  w;
      logic [31:0] a;
      logic [31:0] d;
      int          bad = 0;
      for (int i = 0; i < 16; i++) begin
         d = $urandom();
         a = 32'h100 + 32'(i * 4);
         do_op(1'b0, 1'b1, 2'd2, a, d, cyc, err);
         model_write(a, 2'd2, d);
      end
      for (int n = 0; n < 150; n++) begin
         rd  = 1'($urandom_range(0, 1));
         w   = 2'($urandom_range(0, 3));
         a   = ($urandom() & 32'hFFFF_F000) | 32'h100 |
               32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
         d   = $urandom();
         mis = ALIGN_CHK && is_misaligned(a, w);
         do_op(rd, !rd, w, a, d, cyc, err);
         if (rd) begin
            exp_cyc   = int'(LAT) + 1;
            exp_rdata = mis ? 32'd0 : model_read(a, w);
         end else begin
            exp_cyc = (size_of(w) == 4) ? 2 : int'(LAT) + 2;
            if (!mis) model_write(a, w, d);
         end
         checks++;
         if (cyc != exp_cyc || err !== mis || bus_read_data !== exp_rdata) begin
            failures++;
            bad++;
            if (bad <= 10)
               $display("FAIL random_op%0d rd=%0b w=%0d a=%h: got busy %0d err %b rdata %h expected busy %0d err %b rdata %h",
                        n, rd, w, a, cyc, err, bus_read_data, exp_cyc, mis, exp_rdata);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_align();
      test_overlap();
      test_simultaneous();
      test_reset_commit();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
